arqt_led_sequencer: RTL
=======================

ARQT_LED_SEQUENCER -- requirements
Module: arqt_led_sequencer

Interface
REQ-001 Parameter CNT_W, default 24: width of the step-period counter and of the PERIOD register.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 s_address  input  2  CPU slave register select.
REQ-005 s_chipselect  input  1  CPU slave select.
REQ-006 s_write_n  input  1  CPU slave write strobe, active-low.
REQ-007 s_writedata  input  32  CPU slave write data.
REQ-008 s_readdata  output  32  CPU slave read data, combinational from s_address, zero-latency.
REQ-009 m_address  output  2  master address to LED PIO; constant 0.
REQ-010 m_chipselect  output  1  master select to LED PIO.
REQ-011 m_write_n  output  1  master write strobe to LED PIO, active-low.
REQ-012 m_writedata  output  32  master write data: {28'b0, current pattern nibble}.
REQ-013 m_waitrequest  input  1  PIO stall; a write is accepted on a cycle where m_write_n=0 and m_waitrequest=0.

Function
REQ-014 Register map (s_chipselect=1, s_write_n=0 writes): addr0 CTRL [0]=enable, [1]=oneshot; addr1 PERIOD [CNT_W-1:0]; addr2 PATTERN [15:0], four 4-bit steps, step n at [4n+3:4n]; addr3 STATUS.
REQ-015 STATUS reads [1:0]=step index, [2]=busy (state != IDLE), [3]=done; writing addr3 with bit3=1 clears done; other STATUS bits are read-only.
REQ-016 Unused read bits SHALL read 0; reads have no side effects.
REQ-017 FSM states: IDLE, WRITE, WAIT.
REQ-018 IDLE -> WRITE on the cycle after enable is 1; step index loaded to 0 on entry.
REQ-019 In WRITE: m_chipselect=1, m_write_n=0, m_writedata=PATTERN nibble of the current step, held stable until accepted.
REQ-020 WRITE -> WAIT on acceptance; counter loaded with PERIOD-1 (PERIOD=0 treated as 1).
REQ-021 In WAIT the counter decrements by 1 per cycle; at count 0 the step index increments modulo 4 and the FSM goes to WRITE.
REQ-022 Step period from one accepted write to the next write request SHALL be PERIOD+1 cycles with m_waitrequest=0 (PERIOD cycles WAIT + 1 cycle transition).
REQ-023 Oneshot: when count reaches 0 in WAIT with step index 3 and oneshot=1, done is set, CTRL.enable is cleared, FSM -> IDLE, and no further write is issued.
REQ-024 Enable cleared while in WAIT: FSM -> IDLE the next cycle; step index retained.
REQ-025 Enable cleared while in WRITE: the pending write SHALL complete (strobe held until accepted), then FSM -> IDLE.
REQ-026 PERIOD and PATTERN writes during operation take effect at the next counter load or next WRITE entry, never mid-transfer.
REQ-027 CPU write setting done and hardware setting done in the same cycle: hardware set wins.
REQ-028 Outside WRITE: m_chipselect=0, m_write_n=1, m_writedata=0.

Reset
REQ-029 Reset SHALL force IDLE, all registers and counter to 0, done=0, m_chipselect=0, m_write_n=1, m_writedata=0, s_readdata=0 for address 0 content, independent of clk.
REQ-030 Reset asserted mid-WRITE SHALL drop the master strobe immediately; no write completes.

Verification
REQ-031 PATTERN=0x8421, PERIOD=3, CTRL=0x1, waitrequest=0 -> PIO writes 1,2,4,8,1,... each 4 cycles apart; STATUS.busy=1.
REQ-032 Same with CTRL=0x3 -> exactly four writes 1,2,4,8; then STATUS=0x8 with step index 3->0 wrap noted, CTRL reads 0x2.
REQ-033 waitrequest held 1 for 5 cycles in WRITE -> strobe and data 0x1 held stable 5 cycles, accepted on 6th; period counts from acceptance.
REQ-034 PERIOD=0 -> writes every 2 cycles; clear enable in WAIT -> IDLE next cycle, no further writes.
REQ-035 Clear enable during stalled WRITE, then release waitrequest -> that write completes, FSM IDLE, busy=0.
REQ-036 Assert reset mid-WRITE -> m_write_n=1 asynchronously, all STATUS/CTRL read 0 after release.

Source files
------------

// File: rtl/arqt_led_sequencer.sv
// LED pattern sequencer: a CPU-programmed four-step nibble pattern is pushed to an
// LED PIO through a master write port, one step every PERIOD+1 cycles.
module arqt_led_sequencer #(
    parameter int CNT_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    // CPU slave port
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    // LED PIO master port
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    // FSM state for observation
    output logic [1:0]  dbg_state
);

    // Master handshake: while in WRITE the strobe (m_chipselect=1, m_write_n=0) and
    // m_writedata are held stable; the transfer completes on the cycle the strobe is
    // high and m_waitrequest is low. The slave port has no stall: writes take effect
    // on the edge where s_chipselect=1 and s_write_n=0, reads are combinational.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0]       ADDR_CTRL    = 2'd0;
    localparam logic [1:0]       ADDR_PERIOD  = 2'd1;
    localparam logic [1:0]       ADDR_PATTERN = 2'd2;
    localparam logic [1:0]       ADDR_STATUS  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic             enable_q, enable_d;
    logic             oneshot_q, oneshot_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [15:0]      pattern_q, pattern_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [3:0]       data_q, data_d;

    logic             cpu_wr;
    logic             accept;
    logic             hw_done_set;
    logic             hw_enable_clr;
    logic [1:0]       idx_next;
    logic [CNT_W-1:0] cnt_load;
    logic [31:0]      period_rd;
    logic             unused_wdata;

    assign cpu_wr       = s_chipselect & ~s_write_n;
    assign accept       = (state_q == ST_WRITE) & ~m_waitrequest;
    assign idx_next     = idx_q + 2'd1;
    // A PERIOD of zero behaves as one so the sequencer never stalls in WAIT.
    assign cnt_load     = (period_q == '0) ? '0 : (period_q - CNT_ONE);
    assign unused_wdata = ^s_writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
            period_q  <= '0;
            pattern_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            oneshot_q <= oneshot_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    // Sequencing FSM. The output nibble is captured on entry to WRITE so later
    // PATTERN writes cannot disturb a transfer already in flight.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        hw_done_set   = 1'b0;
        hw_enable_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    state_d = ST_WRITE;
                    idx_d   = 2'd0;
                    data_d  = pattern_q[3:0];
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    cnt_d   = cnt_load;
                    state_d = enable_q ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    idx_d = idx_next;
                    if (oneshot_q && (idx_q == 2'd3)) begin
                        state_d       = ST_IDLE;
                        hw_done_set   = 1'b1;
                        hw_enable_clr = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        data_d  = pattern_q[{idx_next, 2'b00} +: 4];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register file. A CPU CTRL write in the same cycle as the oneshot auto-clear
    // keeps the CPU value; for done the hardware set takes priority.
    always_comb begin
        enable_d  = enable_q;
        oneshot_d = oneshot_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        done_d    = done_q;
        if (cpu_wr) begin
            case (s_address)
                ADDR_CTRL: begin
                    enable_d  = s_writedata[0];
                    oneshot_d = s_writedata[1];
                end
                ADDR_PERIOD:  period_d  = s_writedata[CNT_W-1:0];
                ADDR_PATTERN: pattern_d = s_writedata[15:0];
                ADDR_STATUS: begin
                    if (s_writedata[3]) begin
                        done_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (hw_enable_clr && !(cpu_wr && (s_address == ADDR_CTRL))) begin
            enable_d = 1'b0;
        end
        if (hw_done_set) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        period_rd              = '0;
        period_rd[CNT_W-1:0]   = period_q;
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            ADDR_CTRL:    s_readdata = {30'd0, oneshot_q, enable_q};
            ADDR_PERIOD:  s_readdata = period_rd;
            ADDR_PATTERN: s_readdata = {16'd0, pattern_q};
            ADDR_STATUS:  s_readdata = {28'd0, done_q, (state_q != ST_IDLE), idx_q};
            default:      s_readdata = '0;
        endcase
    end

    always_comb begin
        m_address    = 2'b00;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = '0;
        if (state_q == ST_WRITE) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_writedata  = {28'd0, data_q};
        end
    end

    assign dbg_state = state_q;

endmodule
